// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bundle: imem request/response, redirect, decode handshake
// master: the fetch stage (drives imem requests and the if_* decode outputs)
// slave : the environment (memory, branch unit and decode)
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_pc, if_instr, if_opcode, if_funct3, if_funct7,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_pc, if_instr, if_opcode, if_funct3, if_funct7,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem handshake, in-order instruction buffer
// Ports: clk; rst_n (synchronous, active low); bus (instr_fetch_if.master).
// Optional feature macro IFETCH_BYPASS_EN: a response arriving while the buffer is
// empty is presented to decode combinationally in the same cycle.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW  = CW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   tag_q        [FIFO_DEPTH];

    logic          rsp_live, rsp_stale, rsp_keep, bypass;
    logic          if_valid_w, pop, fifo_pop, fifo_push, tag_push;
    logic          req_valid, accept;
    logic [31:0]   tag_pc, head_instr, head_pc, out_instr;
    logic [OW-1:0] occupancy, credit_lim;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // A response while nothing is outstanding is ignored outright.
        rsp_live  = bus.imem_rsp_valid && (inflight_q != '0);
        rsp_stale = rsp_live && (discard_q != '0);
        rsp_keep  = rsp_live && (discard_q == '0) && !bus.redirect_valid;
        tag_pc    = tag_q[tag_head_q];
`ifdef IFETCH_BYPASS_EN
        bypass    = rst_n && rsp_keep && (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        if_valid_w = (count_q != '0) || bypass;
        head_instr = bypass ? bus.imem_rsp_data : fifo_instr_q[head_q];
        head_pc    = bypass ? tag_pc : fifo_pc_q[head_q];
        out_instr  = if_valid_w ? head_instr : NOP;
        pop        = if_valid_w && bus.if_ready;
        fifo_pop   = pop && !bypass;
        // A bypassed word consumed by decode never touches the buffer.
        fifo_push  = rsp_keep && !(bypass && bus.if_ready);

        // Credit: everything outstanding or buffered must fit in the buffer.
        // A pop or a dropped stale response this cycle frees one slot early.
        occupancy  = OW'(inflight_q) + OW'(count_q);
        credit_lim = OW'(FIFO_DEPTH) + OW'(pop) + OW'(rsp_stale);
        req_valid  = rst_n && (occupancy < credit_lim);
        accept     = req_valid && bus.imem_req_ready;

        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end

        inflight_d = inflight_q + CW'(accept) - CW'(rsp_live);
        discard_d  = discard_q - CW'(rsp_stale);
        // Everything still outstanding after a redirect belongs to the old path.
        if (bus.redirect_valid) begin
            discard_d = inflight_d;
        end

        tag_push   = 1'b0;
        tag_head_d = tag_head_q;
        tag_tail_d = tag_tail_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            tag_head_d = '0;
            tag_tail_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (accept) begin
                tag_push   = 1'b1;
                tag_tail_d = ptr_inc(tag_tail_q);
            end
            if (rsp_keep) begin
                tag_head_d = ptr_inc(tag_head_q);
            end
            if (fifo_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (fifo_pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_head_q <= tag_head_d;
            tag_tail_q <= tag_tail_d;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_instr_q[tail_q] <= bus.imem_rsp_data;
            fifo_pc_q[tail_q]    <= tag_pc;
        end
        if (tag_push) begin
            tag_q[tag_tail_q] <= pc_q;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_w;
    assign bus.if_instr       = out_instr;
    assign bus.if_pc          = if_valid_w ? head_pc : 32'h0;
    assign bus.if_opcode      = out_instr[6:0];
    assign bus.if_funct3      = out_instr[14:12];
    assign bus.if_funct7      = out_instr[31:25];
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with an imem model and decode scoreboard
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    int arm = 0;
    logic fired = 1'b0;
    logic [31:0] arm_pc = '0;
    logic [31:0] model_pc = RST_PC;
    pend_t pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];

    logic        s_req_valid, s_if_valid;
    logic [31:0] s_req_addr, s_if_pc, s_if_instr;
    logic [16:0] s_fields;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h180) return 32'h00A0_0093;
        return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int pb;
        int due;
        logic [31:0] e;
        logic [31:0] w;
        pb = pending.size();
        if (rst_n && pb > 0 && pending[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pending[0].addr);
            pending.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        if ((arm == 1 && pb == 2 && !bus.imem_rsp_valid) ||
            (arm == 2 && pb == 2 && bus.imem_rsp_valid && bus.imem_req_valid && bus.imem_req_ready)) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = arm_pc;
            arm   = 0;
            fired = 1'b1;
        end
        #3;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_if_valid  = bus.if_valid;
        s_if_pc     = bus.if_pc;
        s_if_instr  = bus.if_instr;
        s_fields    = {bus.if_funct7, bus.if_funct3, bus.if_opcode};
        if (!rst_n) begin
            pending.delete();
            exp_q.delete();
            model_pc = RST_PC;
            last_due = 0;
        end else begin
            if (bus.if_valid && bus.if_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected observed_pc=%h expected=no instruction", bus.if_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    w = mem_word(e);
                    check("sb_pc", bus.if_pc, e);
                    check("sb_instr", bus.if_instr, w);
                    check("sb_fields", {15'h0, s_fields}, {15'h0, w[31:25], w[14:12], w[6:0]});
                end
            end
            if (!bus.if_valid) begin
                check("idle_instr", bus.if_instr, NOP);
                check("idle_pc", bus.if_pc, 32'h0);
                check("idle_fields", {15'h0, s_fields}, {15'h0, 7'h00, 3'h0, 7'h13});
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, model_pc);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pending.push_back('{bus.imem_req_addr, due});
                if (!bus.redirect_valid) begin
                    exp_q.push_back(model_pc);
                    acc_log.push_back(bus.imem_req_addr);
                end
                model_pc = model_pc + 32'd4;
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                model_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_first_if(input string tag, input logic [31:0] exp_pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (s_if_valid) begin
                seen = 1'b1;
                check(tag, s_if_pc, exp_pc);
            end
        end
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL %s_timeout observed=no if_valid expected=if_valid within 40 cycles", tag);
        end
    endtask

    task automatic wait_fire(input string tag, input int mode, input logic [31:0] target);
        fired  = 1'b0;
        arm    = mode;
        arm_pc = target;
        for (int i = 0; i < 40 && !fired; i++) step();
        arm = 0;
        total++;
        assert (fired) else begin
            bad++;
            $error("FAIL %s observed=condition not reached expected=reached within 40 cycles", tag);
        end
    endtask

    initial begin
        logic        c1_valid;
        logic [31:0] c1_pc;
        logic [16:0] c1_fields;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        step();
        step();
        check("rst_req_valid", {31'h0, s_req_valid}, 32'd0);
        check("rst_if_valid", {31'h0, s_if_valid}, 32'd0);
        check("rst_req_addr", s_req_addr, RST_PC);
        check("rst_if_instr", s_if_instr, NOP);
        check("rst_if_pc", s_if_pc, 32'h0);

        // Straight-line fetch with 1-cycle memory
        rst_n = 1'b1;
        step();
        check("c0_req_valid", {31'h0, s_req_valid}, 32'd1);
        check("c0_req_addr", s_req_addr, 32'h100);
        check("c0_if_valid", {31'h0, s_if_valid}, 32'd0);
        step();
        check("c1_req_addr", s_req_addr, 32'h104);
        check("c1_if_valid_latency", {31'h0, s_if_valid}, BYP);
        c1_valid  = s_if_valid;
        c1_pc     = s_if_pc;
        c1_fields = s_fields;
        step();
        check("c2_req_valid", {31'h0, s_req_valid}, 32'd1);
        check("c2_req_addr", s_req_addr, 32'h108);
        check("first_if_pc", c1_valid ? c1_pc : s_if_pc, 32'h100);
        check("first_opcode", {25'h0, c1_valid ? c1_fields[6:0] : s_fields[6:0]}, 32'h13);
        check("first_funct3", {29'h0, c1_valid ? c1_fields[9:7] : s_fields[9:7]}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("throughput_if_valid", {31'h0, s_if_valid}, 32'd1);
            check("throughput_req_valid", {31'h0, s_req_valid}, 32'd1);
        end

        // Decode backpressure: credits run out, nothing lost
        bus.if_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_req_valid_low", {31'h0, s_req_valid}, 32'd0);
            check("bp_if_valid_held", {31'h0, s_if_valid}, 32'd1);
        end
        bus.if_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Redirect with two requests outstanding, 3-cycle memory
        lat = 3;
        for (int i = 0; i < 8; i++) step();
        wait_fire("redir_two_inflight", 1, 32'h0000_0203);
        step();
        check("redir_next_addr", s_req_addr, 32'h200);
        check("redir_next_if_valid", {31'h0, s_if_valid}, 32'd0);
        wait_first_if("redir_first_pc", 32'h200);

        // Redirect coincident with an accept and a response
        for (int i = 0; i < 6; i++) step();
        wait_fire("redir_setup", 1, 32'h0000_0300);
        wait_fire("redir_coincident", 2, 32'h0000_0400);
        wait_first_if("coinc_first_pc", 32'h400);

        // PC wrap at the top of the address space
        lat = 1;
        for (int i = 0; i < 4; i++) step();
        acc_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        for (int i = 0; i < 30 && acc_log.size() < 3; i++) step();
        total++;
        assert (acc_log.size() >= 3) else begin
            bad++;
            $error("FAIL wrap_timeout observed=%0d accepts expected=3", acc_log.size());
        end
        if (acc_log.size() >= 3) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", acc_log[2], 32'h0000_0000);
        end

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            bus.if_ready       = ($urandom_range(0, 3) != 0);
            bus.imem_req_ready = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc    = $urandom;
            step();
        end

        // Drain: every accepted, non-flushed request must reach decode
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("drain_all_delivered", exp_q.size(), 32'd0);

        // Reset mid-operation
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        step();
        check("mid_rst_req_valid", {31'h0, s_req_valid}, 32'd0);
        check("mid_rst_if_valid", {31'h0, s_if_valid}, 32'd0);
        check("mid_rst_req_addr", s_req_addr, RST_PC);
        check("mid_rst_if_instr", s_if_instr, NOP);
        rst_n = 1'b1;
        step();
        check("post_rst_req_valid", {31'h0, s_req_valid}, 32'd1);
        check("post_rst_req_addr", s_req_addr, RST_PC);
        wait_first_if("post_rst_first_pc", RST_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the control unit. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready handshake. Returned instruction words are buffered in a small in-order FIFO and presented to decode with their PC and pre-split `opcode`/`funct3`/`funct7` fields. Branch/jump redirects flush the FIFO and discard stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Also the cap on in-flight requests plus buffered entries. Legal values are 2..8.

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_req_addr`  out  32: fetch address, word-aligned.
- `imem_rsp_valid`  in  1: response valid. Responses are in order, at least 1 cycle after acceptance, with no backpressure.
- `imem_rsp_data`  in  32: instruction word.
- `redirect_valid`  in  1: branch or jump taken.
- `redirect_pc`  in  32: new PC. Bits [1:0] are ignored and treated as 0.
- `if_valid`  out  1: instruction available to decode.
- `if_ready`  in  1: decode accepts.
- `if_pc`  out  32: PC of the presented instruction.
- `if_instr`  out  32: presented instruction.
- `if_opcode`  out  7: `if_instr[6:0]`.
- `if_funct3`  out  3: `if_instr[14:12]`.
- `if_funct7`  out  7: `if_instr[31:25]`.

## Operation
- **Registered state:**
  - `pc`, the next fetch address.
  - `inflight`, accepted requests not yet returned, 0..FIFO_DEPTH.
  - `discard`, responses still to be dropped.
  - The FIFO: instr/pc pairs, with head, tail and count.
- **Credit rule:** `imem_req_valid` = `rst_n` && (`inflight` + `count` + live-response adjustment < FIFO_DEPTH). The buffer therefore can never overflow.
- **Request acceptance:** when `imem_req_valid` && `imem_req_ready`:
  - `pc` <= `pc` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - The accepted address is pushed to an internal PC tag queue (depth FIFO_DEPTH), so every response is paired with its address.
- **Request hold:** while valid and not ready, `imem_req_addr` holds stable, except on redirect, which replaces it.
- **Response handling:** a response with `discard` != 0 decrements `discard` and is dropped. Otherwise it is pushed to the FIFO with its tag PC. A response while `inflight` == 0 is ignored.
- **Decode handshake:** the FIFO head drives the `if_*` outputs. The head is popped when `if_valid` && `if_ready`.
- **Redirect cycle:**
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - The FIFO and the tag queue are flushed.
  - `discard` <= the in-flight count after this cycle's accept and response. A request accepted in the redirect cycle is therefore also discarded, and a response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is still honoured, because decode consumed it.
- **Idle outputs:** when `if_valid` = 0, `if_instr` = 32'h0000_0013 (NOP), `if_pc` = 0, and the fields are derived from the NOP.
- **Simultaneous push and pop:** count is unchanged and order is preserved.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - `pc` = RESET_PC; `inflight`, `discard` and `count` = 0.
  - `imem_req_valid` = 0, `if_valid` = 0, `imem_req_addr` = RESET_PC.
  - `if_instr` = NOP, `if_pc` = 0.
- **First request:** in the first cycle with `rst_n` high, `imem_req_valid` = 1 and `imem_req_addr` = RESET_PC.
- **Reset mid-operation:** all state is cleared. Responses to pre-reset requests are the memory's responsibility; the bench resets memory together with this block.
- **Response to decode:** the response in cycle N is visible on `if_*` in cycle N+1, registered, with the FIFO non-empty. See Configuration for the bypass.
- **Redirect to decode:** a redirect in cycle N gives `if_valid` = 0 in N+1 and `imem_req_addr` = the redirect target in N+1. The first new instruction is visible no earlier than the memory latency + 1 cycles after acceptance.
- **Throughput:** with 1-cycle memory latency and `if_ready` tied high, one instruction per cycle is sustained.

## Configuration
- `IFETCH_BYPASS_EN`:
  - **Defined:** when the FIFO is empty and a non-discarded response arrives, `if_*` present it combinationally in the same cycle, with `if_valid` = 1. If `if_ready` = 1 it is consumed without entering the FIFO; otherwise it is written to the FIFO. This saves one cycle of fetch-to-decode latency.
  - **Undefined:** every response goes through the FIFO, with the registered N+1 timing.

## Test plan
- **Reset and straight-line fetch:** reset with RESET_PC=0x100 and 1-cycle memory returning `0x00A00093`, then release reset. Required: request addresses 0x100, 0x104, 0x108 on consecutive cycles; `if_opcode` = 0x13, `if_funct3` = 0, `if_pc` = 0x100 first.
- **Decode backpressure:** hold `if_ready` = 0 for 5 cycles. Required: `imem_req_valid` drops after `inflight` + `count` = 2; no response is lost; on release, PCs come out in order 0x100, 0x104.
- **Redirect with 2 in flight:** 3-cycle memory, redirect to 0x203 while 2 requests are outstanding. Required: next `imem_req_addr` = 0x200; both stale responses dropped; first `if_pc` = 0x200.
- **Redirect coincident with accept and response:** required: the accepted request is discarded as well, and `discard` = 2.
- **PC wrap:** RESET_PC = 0xFFFF_FFF8. Required: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Bypass:** with `IFETCH_BYPASS_EN` defined and an empty FIFO, a response in cycle N gives `if_valid` = 1 in cycle N. Undefined gives `if_valid` = 1 in N+1.
